// File: rtl/data_memory_bridge_pkg.sv
// Shared types and constants for the CPU data-memory to byte-SRAM bridge.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

  // Little-endian byte lane k of a word (lane 0 is bits 7:0).
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [LANE_W-1:0] k);
    return BYTE_W'(w >> {k, 3'b000});
  endfunction

endpackage

// File: rtl/data_memory_bridge_if.sv
// CPU data-memory port: word request from the core, read data and completion back.
interface data_memory_bridge_if;
  import mem_pkg::*;

  logic [WORD_W-1:0] data_memory_a;
  logic              data_memory_read;
  logic              data_memory_write;
  logic [WORD_W-1:0] data_memory_out_v;
  logic [WORD_W-1:0] data_memory_in_v;
  logic              data_memory_ready;

  modport master (
    output data_memory_a,
    output data_memory_read,
    output data_memory_write,
    output data_memory_out_v,
    input  data_memory_in_v,
    input  data_memory_ready
  );

  modport slave (
    input  data_memory_a,
    input  data_memory_read,
    input  data_memory_write,
    input  data_memory_out_v,
    output data_memory_in_v,
    output data_memory_ready
  );

endinterface

// File: rtl/data_memory_bridge.sv
// Serializes 32-bit CPU word accesses into four byte accesses on an 8-bit synchronous SRAM.
module data_memory_bridge
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  data_memory_bridge_if.slave  cpu,
  output logic [ADDR_W-1:0]    sram_a,
  output logic                 sram_re,
  output logic                 sram_we,
  output logic [BYTE_W-1:0]    sram_wdata,
  input  logic [BYTE_W-1:0]    sram_rdata
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
  localparam int unsigned       SHADOW_W  = WORD_W - BYTE_W;

  state_t              r_state,      w_state_nxt;
  logic [LANE_W-1:0]   r_k,          w_k_nxt;
  logic                r_is_rd,      w_is_rd_nxt;
  logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
  logic [WORD_W-1:0]   r_wdata,      w_wdata_nxt;
  logic [ADDR_W-1:0]   r_sram_a,     w_sram_a_nxt;
  logic                r_sram_re,    w_sram_re_nxt;
  logic                r_sram_we,    w_sram_we_nxt;
  logic [BYTE_W-1:0]   r_sram_wdata, w_sram_wdata_nxt;
  logic                r_ready,      w_ready_nxt;
  logic                r_rd_ready,   w_rd_ready_nxt;

  logic                r_cap_v;
  logic [SHADOW_W-1:0] r_shadow;
  logic [WORD_W-1:0]   r_in_v;

  logic [ADDR_W-1:0]   w_req_a;
  logic [ADDR_W-1:0]   w_lane_a;
  logic [WORD_W-1:0]   w_rd_word;
  logic                w_unused_addr_hi;

  assign w_req_a          = ADDR_W'(cpu.data_memory_a);
  assign w_lane_a         = r_addr + ADDR_W'(r_k);
  assign w_unused_addr_hi = ^cpu.data_memory_a[WORD_W-1:ADDR_W];

  // State, lane counter and SRAM/completion outputs, all registered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_is_rd      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sram_a     <= '0;
      r_sram_re    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_wdata <= '0;
      r_ready      <= 1'b0;
      r_rd_ready   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_is_rd      <= w_is_rd_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_sram_a     <= w_sram_a_nxt;
      r_sram_re    <= w_sram_re_nxt;
      r_sram_we    <= w_sram_we_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_ready      <= w_ready_nxt;
      r_rd_ready   <= w_rd_ready_nxt;
    end
  end

  // Next state and next register values; lane k is issued on the edge that leaves lane k-1.
  always_comb begin
    w_state_nxt      = r_state;
    w_k_nxt          = r_k;
    w_is_rd_nxt      = r_is_rd;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_sram_a_nxt     = r_sram_a;
    w_sram_re_nxt    = 1'b0;
    w_sram_we_nxt    = 1'b0;
    w_sram_wdata_nxt = r_sram_wdata;
    w_ready_nxt      = 1'b0;
    w_rd_ready_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (cpu.data_memory_write) begin
          w_addr_nxt       = w_req_a;
          w_wdata_nxt      = cpu.data_memory_out_v;
          w_is_rd_nxt      = 1'b0;
          w_sram_a_nxt     = w_req_a;
          w_sram_we_nxt    = 1'b1;
          w_sram_wdata_nxt = word_byte(cpu.data_memory_out_v, '0);
          w_k_nxt          = LANE_W'(1);
          w_state_nxt      = WRITE;
        end else if (cpu.data_memory_read) begin
          w_addr_nxt    = w_req_a;
          w_is_rd_nxt   = 1'b1;
          w_sram_a_nxt  = w_req_a;
          w_sram_re_nxt = 1'b1;
          w_k_nxt       = LANE_W'(1);
          w_state_nxt   = READ;
        end
      end
      WRITE: begin
        w_sram_a_nxt     = w_lane_a;
        w_sram_we_nxt    = 1'b1;
        w_sram_wdata_nxt = word_byte(r_wdata, r_k);
        w_k_nxt          = r_k + LANE_W'(1);
        if (r_k == LAST_LANE) begin
          w_state_nxt = DONE;
        end
      end
      READ: begin
        w_sram_a_nxt  = w_lane_a;
        w_sram_re_nxt = 1'b1;
        w_k_nxt       = r_k + LANE_W'(1);
        if (r_k == LAST_LANE) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_ready_nxt    = 1'b1;
        w_rd_ready_nxt = r_is_rd;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Returned bytes shift in lane order; the last byte arrives in the ready cycle and bypasses the shadow.
  assign w_rd_word = {sram_rdata, r_shadow};

  // Read-data capture and the held CPU read-data register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cap_v  <= 1'b0;
      r_shadow <= '0;
      r_in_v   <= '0;
    end else begin
      r_cap_v <= r_sram_re;
      if (r_cap_v) begin
        r_shadow <= {sram_rdata, r_shadow[SHADOW_W-1:BYTE_W]};
      end
      if (r_rd_ready) begin
        r_in_v <= w_rd_word;
      end
    end
  end

  assign cpu.data_memory_in_v  = r_rd_ready ? w_rd_word : r_in_v;
  assign cpu.data_memory_ready = r_ready;
  assign sram_a                = r_sram_a;
  assign sram_re               = r_sram_re;
  assign sram_we               = r_sram_we;
  assign sram_wdata            = r_sram_wdata;

endmodule
